// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: PC stepping, FSM states and
// the layout of an output-queue entry.
package fetch_pkg;

  localparam int unsigned INSTRUCTION_BYTES = 4;
  localparam int unsigned PC_INCREMENT      = 4;

  typedef enum logic [0:0] {
    StSettle = 1'b0,
    StWait   = 1'b1
  } fetch_state_e;

  // Queue entries are {pc, instruction}, pc in the upper bits.
  function automatic int unsigned entry_width(input int unsigned addr_w,
                                              input int unsigned instr_w);
    return addr_w + instr_w;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO holding fetched {pc, instruction} entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_queue #(
  parameter int unsigned DEPTH_BITWIDTH = 1,
  parameter int unsigned WIDTH          = 42
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Depth = 1 << DEPTH_BITWIDTH;
  localparam int unsigned PtrW  = DEPTH_BITWIDTH + 1;

  logic [WIDTH-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PtrW-1] != rd_q[PtrW-1]) &&
                   (wr_q[PtrW-2:0] == rd_q[PtrW-2:0]);
  assign data_o  = mem_q[rd_q[PtrW-2:0]];

  // A push into a full queue is fine when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[PtrW-2:0]] <= data_i;
        wr_q                  <= wr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PtrW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the cache read port and hands
// {pc, instruction} pairs to decode through a small queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_BITWIDTH     = 10,
  parameter int unsigned INSTRUCTION_BITWIDTH = 32,
  parameter int unsigned RESET_ADDRESS        = 0,
  parameter int unsigned QUEUE_DEPTH_BITWIDTH = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            redirect_en_i,
  input  logic [ADDRESS_BITWIDTH-1:0]     redirect_pc_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [INSTRUCTION_BITWIDTH-1:0] out_instr_o,
  output logic [ADDRESS_BITWIDTH-1:0]     out_pc_o,
  output logic [ADDRESS_BITWIDTH-1:0]     cache_addr_o,
  input  logic [INSTRUCTION_BITWIDTH-1:0] cache_dout_i,
  input  logic                            cache_rdy_i,
  input  logic                            cache_bsy_i
);

  localparam int unsigned EntryW = entry_width(ADDRESS_BITWIDTH, INSTRUCTION_BITWIDTH);
  localparam logic [ADDRESS_BITWIDTH-1:0] AlignMask =
      ~ADDRESS_BITWIDTH'(INSTRUCTION_BYTES - 1);
  localparam logic [ADDRESS_BITWIDTH-1:0] ResetPc =
      ADDRESS_BITWIDTH'(RESET_ADDRESS) & AlignMask;

  fetch_state_e                state_q, state_d;
  logic [ADDRESS_BITWIDTH-1:0] pc_q, pc_d;
  logic                        q_full, q_empty;
  logic                        pop, accept;
  logic [EntryW-1:0]           q_head;

  // A redirect voids both the decode pop and any cache accept of this cycle.
  assign pop    = !q_empty && out_ready_i && !redirect_en_i;
  assign accept = (state_q == StWait) && cache_rdy_i && !cache_bsy_i &&
                  (!q_full || pop) && !redirect_en_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_en_i) begin
      state_d = StSettle;
      pc_d    = redirect_pc_i & AlignMask;
    end else begin
      unique case (state_q)
        StSettle: state_d = StWait;
        StWait: begin
          if (accept) begin
            state_d = StSettle;
            pc_d    = pc_q + ADDRESS_BITWIDTH'(PC_INCREMENT);
          end
        end
        default: state_d = StSettle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StSettle;
      pc_q    <= ResetPc;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue #(
    .DEPTH_BITWIDTH (QUEUE_DEPTH_BITWIDTH),
    .WIDTH          (EntryW)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept),
    .data_i  ({pc_q, cache_dout_i}),
    .pop_i   (pop),
    .flush_i (redirect_en_i),
    .data_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign cache_addr_o = pc_q;
  assign out_valid_o  = !q_empty;
  assign out_pc_o     = q_head[EntryW-1 -: ADDRESS_BITWIDTH];
  assign out_instr_o  = q_head[INSTRUCTION_BITWIDTH-1:0];

endmodule
